// File: rtl/i2c_reg_handler.sv
// Single-register I2C master: one register write, or one register read using a repeated START.
// The result is held on a strobe until the upstream side acknowledges it, then done pulses.
module i2c_reg_handler #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_begin,
    input  logic       i_writeEnable,
    input  logic [6:0] i_i2cAddress,
    input  logic [7:0] i_regAddress,
    input  logic [7:0] i_txData,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] o_rxData,
    output logic       o_nack,
    output logic       o_busy,
    output logic       wbEnable,
    input  logic       i_wbAck,
    output logic       o_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_DATA, S_RSTART,
        S_ADDR_R, S_READ, S_STOP, S_RESULT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  rx_q, rx_d;
    logic        nack_q, nack_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic        we_q;
    logic [6:0]  addr_q;
    logic [7:0]  reg_q;
    logic [7:0]  tx_q;
    logic        sda_meta_q, sda_sync_q;

    logic        tick;
    logic        accept;
    logic        phase_end;
    logic        byte_end;
    logic        sample;
    logic        in_byte;
    logic        in_tx_byte;
    logic [7:0]  cur_byte;

    assign i2c_scl = scl_oe_q ? 1'b0 : 1'bz;
    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

    assign o_rxData = rx_q;
    assign o_nack   = nack_q;

    assign tick       = (div_q == 10'(CLK_DIV - 1));
    assign accept     = (state_q == S_IDLE) && i_begin;
    assign phase_end  = tick && (qtr_q == 2'd3);
    assign byte_end   = phase_end && (bit_q == 4'd8);
    assign sample     = tick && (qtr_q == 2'd2);
    assign in_tx_byte = (state_q == S_ADDR_W) || (state_q == S_REG) ||
                        (state_q == S_DATA)   || (state_q == S_ADDR_R);
    assign in_byte    = in_tx_byte || (state_q == S_READ);

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            S_ADDR_W: cur_byte = {addr_q, 1'b0};
            S_REG:    cur_byte = reg_q;
            S_DATA:   cur_byte = tx_q;
            S_ADDR_R: cur_byte = {addr_q, 1'b1};
            default:  cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_begin)   state_d = S_START;
            S_START:  if (phase_end) state_d = S_ADDR_W;
            S_ADDR_W: if (byte_end)  state_d = nack_q ? S_STOP : S_REG;
            S_REG:    if (byte_end)  state_d = nack_q ? S_STOP : (we_q ? S_DATA : S_RSTART);
            S_DATA:   if (byte_end)  state_d = S_STOP;
            S_RSTART: if (phase_end) state_d = S_ADDR_R;
            S_ADDR_R: if (byte_end)  state_d = nack_q ? S_STOP : S_READ;
            S_READ:   if (byte_end)  state_d = S_STOP;
            S_STOP:   if (phase_end) state_d = S_RESULT;
            S_RESULT: if (i_wbAck)   state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Pad enables are computed here and registered so the pins never glitch.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        wbEnable = 1'b0;
        o_done   = 1'b0;
        o_busy   = 1'b1;
        case (state_q)
            S_IDLE:   o_busy = 1'b0;
            S_START: begin
                sda_oe_d = 1'b1;
                scl_oe_d = qtr_q[1];
            end
            S_RSTART: begin
                scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe_d = qtr_q[1];
            end
            S_STOP: begin
                scl_oe_d = (qtr_q == 2'd0);
                sda_oe_d = !qtr_q[1];
            end
            S_ADDR_W, S_REG, S_DATA, S_ADDR_R: begin
                scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe_d = (bit_q < 4'd8) && !cur_byte[3'd7 - bit_q[2:0]];
            end
            S_READ:   scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
            S_RESULT: wbEnable = 1'b1;
            S_DONE: begin
                o_done = 1'b1;
                o_busy = 1'b0;
            end
            default:  o_busy = 1'b0;
        endcase
    end

    // Quarter-period timing; counters sit at zero whenever the bus is not in use.
    always_comb begin
        div_d = div_q;
        qtr_d = qtr_q;
        bit_d = bit_q;
        if ((state_q == S_IDLE) || (state_q == S_RESULT) || (state_q == S_DONE)) begin
            div_d = '0;
            qtr_d = '0;
            bit_d = '0;
        end else if (tick) begin
            div_d = '0;
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
                bit_d = (!in_byte || (bit_q == 4'd8)) ? 4'd0 : bit_q + 4'd1;
            end
        end else begin
            div_d = div_q + 10'd1;
        end
    end

    always_comb begin
        rx_d   = rx_q;
        nack_d = nack_q;
        if (accept) begin
            rx_d   = 8'h00;
            nack_d = 1'b0;
        end else if (sample && (state_q == S_READ) && (bit_q < 4'd8)) begin
            rx_d = {rx_q[6:0], sda_sync_q};
        end else if (sample && in_tx_byte && (bit_q == 4'd8) && sda_sync_q) begin
            nack_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            rx_q       <= 8'h00;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 7'h00;
            reg_q      <= 8'h00;
            tx_q       <= 8'h00;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            rx_q       <= rx_d;
            nack_q     <= nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= i2c_sda;
            sda_sync_q <= sda_meta_q;
            if (accept) begin
                we_q   <= i_writeEnable;
                addr_q <= i_i2cAddress;
                reg_q  <= i_regAddress;
                tx_q   <= i_txData;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_handler.sv
// Bench for i2c_reg_handler: behavioural I2C slave on a pulled-up bus, expected results
// queued by the stimulus and checked by an independent monitor that also plays the upstream side.
module tb_i2c_reg_handler;

    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic       nack;
        logic       chk_rx;
        logic [7:0] rx;
        logic [7:0] ack_dly;
        logic [7:0] nbus;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beg = 1'b0;
    logic       we = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] regad = 8'h00;
    logic [7:0] txd = 8'h00;
    logic       wb_ack;
    logic [7:0] rx;
    logic       nack, busy, wb_en, done;
    wire        scl, sda;

    pullup (scl);
    pullup (sda);

    // Slave-side state
    logic       sda_drv;
    logic       slv_en = 1'b0;
    logic [7:0] slv_rd = 8'h00;
    logic [8:0] bus_log[$];

    exp_t       exp_q[$];
    logic [8:0] exp_bus[$];
    int         log_rd = 0;
    int         n_checks = 0;
    int         n_err = 0;

    assign sda = sda_drv ? 1'b0 : 1'bz;

    i2c_reg_handler #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_begin       (beg),
        .i_writeEnable (we),
        .i_i2cAddress  (addr),
        .i_regAddress  (regad),
        .i_txData      (txd),
        .i2c_scl       (scl),
        .i2c_sda       (sda),
        .o_rxData      (rx),
        .o_nack        (nack),
        .o_busy        (busy),
        .wbEnable      (wb_en),
        .i_wbAck       (wb_ack),
        .o_done        (done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Behavioural slave: logs START (0x100), STOP (0x101), every byte seen on the bus,
    // and the master's ack bit after a byte the slave sent (0x102 NACK / 0x103 ACK).
    initial begin
        logic       scl_p, sda_p, is_rd, tx_mode;
        logic [7:0] shf;
        int         bit_i, byte_i;
        scl_p = 1'b1; sda_p = 1'b1; is_rd = 1'b0; shf = 8'h00;
        bit_i = 0; byte_i = 0; sda_drv = 1'b0;
        forever begin
            @(scl or sda);
            tx_mode = is_rd && (byte_i == 1) && slv_en;
            if (scl !== scl_p) begin
                if (scl === 1'b1) begin
                    if (bit_i < 8) begin
                        shf = {shf[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
                        bit_i++;
                    end else if (bit_i == 8) begin
                        if (tx_mode) bus_log.push_back((sda === 1'b0) ? 9'h103 : 9'h102);
                        bit_i = 9;
                    end
                end else begin
                    if (bit_i == 8) begin
                        bus_log.push_back({1'b0, shf});
                        if (tx_mode) begin
                            sda_drv = 1'b0;
                        end else begin
                            if (byte_i == 0) is_rd = shf[0];
                            sda_drv = slv_en;
                        end
                    end else if (bit_i == 9) begin
                        bit_i = 0;
                        byte_i++;
                        sda_drv = 1'b0;
                        if (is_rd && (byte_i == 1) && slv_en) sda_drv = ~slv_rd[7];
                    end else if (tx_mode && (bit_i >= 1) && (bit_i <= 7)) begin
                        sda_drv = ~slv_rd[7 - bit_i];
                    end
                end
            end else if ((sda !== sda_p) && (scl === 1'b1)) begin
                bus_log.push_back((sda === 1'b0) ? 9'h100 : 9'h101);
                bit_i = 0;
                byte_i = 0;
                sda_drv = 1'b0;
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    // Monitor / upstream controller: pops an expectation whenever a result is strobed.
    initial begin
        exp_t       e;
        logic [8:0] ev;
        int         txn;
        txn = 0;
        wb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                log_rd = bus_log.size();
            end else if (wb_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(wb_en), 32'(0));
                    wb_ack = 1'b1;
                    @(negedge clk);
                    wb_ack = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: nack=%0b rx=0x%02h bus_events=%0d", txn, nack, rx,
                             bus_log.size() - log_rd);
                    chk("o_nack", 32'(nack), 32'(e.nack));
                    if (e.chk_rx) chk("o_rxData", 32'(rx), 32'(e.rx));
                    chk("busy_in_result", 32'(busy), 32'(1));
                    chk("bus_len", 32'(bus_log.size() - log_rd), 32'(e.nbus));
                    for (int i = 0; i < int'(e.nbus); i++) begin
                        ev = exp_bus.pop_front();
                        chk("bus_event", (log_rd + i < bus_log.size()) ? 32'(bus_log[log_rd + i]) : 32'h1FF,
                            32'(ev));
                    end
                    log_rd = bus_log.size();
                    for (int i = 0; i < int'(e.ack_dly); i++) begin
                        @(negedge clk);
                        chk("wb_hold", 32'(wb_en), 32'(1));
                        chk("done_hold", 32'(done), 32'(0));
                        chk("nack_hold", 32'(nack), 32'(e.nack));
                        if (e.chk_rx) chk("rx_hold", 32'(rx), 32'(e.rx));
                    end
                    wb_ack = 1'b1;
                    @(negedge clk);
                    wb_ack = 1'b0;
                    chk("wb_drop", 32'(wb_en), 32'(0));
                    chk("done_pulse", 32'(done), 32'(1));
                    chk("busy_clear", 32'(busy), 32'(0));
                    @(negedge clk);
                    chk("done_once", 32'(done), 32'(0));
                end
            end
        end
    end

    task automatic expect_txn(input logic n, input logic c, input logic [7:0] r,
                              input logic [7:0] dly, input logic [7:0] nb);
        exp_q.push_back('{nack: n, chk_rx: c, rx: r, ack_dly: dly, nbus: nb});
    endtask

    // Called at a negedge: pulses i_begin for one cycle, checks acceptance and the first
    // bus edge, then scrambles the inputs to show they are not re-sampled.
    task automatic start_txn(input logic w, input logic [6:0] a, input logic [7:0] r,
                             input logic [7:0] d);
        we = w; addr = a; regad = r; txd = d; beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        chk("busy_rise", 32'(busy), 32'(1));
        @(negedge clk);
        chk("start_sda_low", 32'(sda), 32'(0));
        chk("start_scl_high", 32'(scl), 32'(1));
        we = ~w; addr = ~a; regad = ~r; txd = ~d;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((done !== 1'b1) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got no o_done within %0d cycles want o_done=1", n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl), 32'(1));
        chk("rst_sda", 32'(sda), 32'(1));
        chk("rst_wb", 32'(wb_en), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_nack", 32'(nack), 32'(0));
        chk("rst_rx", 32'(rx), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the address byte (bit 2 of 0xC0, SCL high, SDA low)
        slv_en = 1'b0;
        start_txn(1'b1, 7'h60, 8'h12, 8'h34);
        repeat (54) @(negedge clk);
        chk("pre_rst_scl", 32'(scl), 32'(1));
        chk("pre_rst_sda", 32'(sda), 32'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_scl", 32'(scl), 32'(1));
        chk("mid_rst_sda", 32'(sda), 32'(1));
        chk("mid_rst_wb", 32'(wb_en), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Pull-ups only: address NACK, straight to STOP
        expect_txn(1'b1, 1'b0, 8'h00, 8'd3, 8'd3);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h0C0); exp_bus.push_back(9'h101);
        start_txn(1'b1, 7'h60, 8'h12, 8'h34);
        wait_done();
        repeat (3) @(negedge clk);

        // ACKing slave, write 0x34 to reg 0x12; a second i_begin mid-transaction is ignored
        slv_en = 1'b1;
        expect_txn(1'b0, 1'b0, 8'h00, 8'd2, 8'd5);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h0C0); exp_bus.push_back(9'h012);
        exp_bus.push_back(9'h034); exp_bus.push_back(9'h101);
        start_txn(1'b1, 7'h60, 8'h12, 8'h34);
        repeat (40) @(negedge clk);
        we = 1'b0; addr = 7'h11; regad = 8'h77; beg = 1'b1;
        @(negedge clk);
        beg = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Read reg 0x12 returning 0xA5, upstream holds off the ack for 20 cycles
        slv_rd = 8'hA5;
        expect_txn(1'b0, 1'b1, 8'hA5, 8'd20, 8'd8);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h0C0); exp_bus.push_back(9'h012);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h0C1); exp_bus.push_back(9'h0A5);
        exp_bus.push_back(9'h102); exp_bus.push_back(9'h101);
        start_txn(1'b0, 7'h60, 8'h12, 8'h00);
        wait_done();

        // Back-to-back: new i_begin one cycle after o_done, read 0x3C at 0x2B returning 0x5A
        @(negedge clk);
        slv_rd = 8'h5A;
        expect_txn(1'b0, 1'b1, 8'h5A, 8'd0, 8'd8);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h056); exp_bus.push_back(9'h03C);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h057); exp_bus.push_back(9'h05A);
        exp_bus.push_back(9'h102); exp_bus.push_back(9'h101);
        start_txn(1'b0, 7'h2B, 8'h3C, 8'hFF);
        wait_done();
        repeat (3) @(negedge clk);

        // Read with no slave present: address NACK
        slv_en = 1'b0;
        expect_txn(1'b1, 1'b0, 8'h00, 8'd1, 8'd3);
        exp_bus.push_back(9'h100); exp_bus.push_back(9'h056); exp_bus.push_back(9'h101);
        start_txn(1'b0, 7'h2B, 8'h3C, 8'h00);
        wait_done();
        repeat (5) @(negedge clk);

        chk("results_consumed", 32'(exp_q.size()), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
